// File: rtl/cp0_tlb_regs_if.sv
// CP0 <-> execute-stage / TLB signal bundle for cp0_tlb_regs.
// slave is the register file side, master is whoever drives it.
interface cp0_tlb_regs_if;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic        op_valid;
    logic [1:0]  op;
    logic        op_ready;
    logic        op_done;
    logic        exc_tlb;
    logic [31:0] exc_badvaddr;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic [31:0] tlb_w_hi;
    logic [31:0] tlb_w_lo0;
    logic [31:0] tlb_w_lo1;
    logic [3:0]  tlb_r_index;
    logic        tlb_op_tlbp;
    logic [31:0] tlb_p_index;
    logic [31:0] tlb_r_hi;
    logic [31:0] tlb_r_lo0;
    logic [31:0] tlb_r_lo1;

    modport slave (
        input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, op_valid, op, exc_tlb, exc_badvaddr,
               tlb_p_index, tlb_r_hi, tlb_r_lo0, tlb_r_lo1,
        output mfc0_rdata, op_ready, op_done, tlb_we, tlb_w_index, tlb_w_hi, tlb_w_lo0,
               tlb_w_lo1, tlb_r_index, tlb_op_tlbp
    );

    modport master (
        output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, op_valid, op, exc_tlb, exc_badvaddr,
               tlb_p_index, tlb_r_hi, tlb_r_lo0, tlb_r_lo1,
        input  mfc0_rdata, op_ready, op_done, tlb_we, tlb_w_index, tlb_w_hi, tlb_w_lo0,
               tlb_w_lo1, tlb_r_index, tlb_op_tlbp
    );
endinterface

// File: rtl/cp0_tlb_regs.sv
// CP0 TLB registers (Index/Random/EntryLo0/1/Wired/EntryHi) and tlbp/tlbr/tlbwi/tlbwr sequencer.
// Define TLB_WIRED_EN to implement the Wired register; otherwise Wired reads 0.
module cp0_tlb_regs #(
    parameter int unsigned TLBNUM = 16
) (
    input  logic           clk,
    input  logic           resetn,
    cp0_tlb_regs_if.slave  io_bus
);
    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    localparam logic [1:0] OpTlbp  = 2'b00;
    localparam logic [1:0] OpTlbr  = 2'b01;
    localparam logic [1:0] OpTlbwi = 2'b10;
    localparam logic [1:0] OpTlbwr = 2'b11;

    localparam logic [4:0] AddrIndex  = 5'd0;
    localparam logic [4:0] AddrRandom = 5'd1;
    localparam logic [4:0] AddrLo0    = 5'd2;
    localparam logic [4:0] AddrLo1    = 5'd3;
    localparam logic [4:0] AddrWired  = 5'd6;
    localparam logic [4:0] AddrHi     = 5'd10;

    localparam logic [3:0] RandTop = 4'(TLBNUM - 1);

    state_e      r_state, w_state_nxt;
    logic [1:0]  r_op;
    logic        r_index_p;
    logic [3:0]  r_index;
    logic [3:0]  r_random;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic [25:0] r_lo0, r_lo1;

    logic [3:0]  w_wired;
    logic        w_wired_load;
    logic        w_accept, w_exec_tlbp, w_exec_tlbr;
    logic        w_wr_index, w_wr_lo0, w_wr_lo1, w_wr_hi;
    logic        w_tlb_we, w_tlb_op_tlbp;
    logic [3:0]  w_tlb_w_index;
    logic [31:0] w_index_full, w_hi_full, w_rdata;
    logic        w_unused;

    assign w_accept    = (r_state == StIdle) && io_bus.op_valid;
    assign w_exec_tlbp = (r_state == StExec) && (r_op == OpTlbp);
    assign w_exec_tlbr = (r_state == StExec) && (r_op == OpTlbr);
    assign w_wr_index  = io_bus.mtc0_we && (io_bus.mtc0_addr == AddrIndex);
    assign w_wr_lo0    = io_bus.mtc0_we && (io_bus.mtc0_addr == AddrLo0);
    assign w_wr_lo1    = io_bus.mtc0_we && (io_bus.mtc0_addr == AddrLo1);
    assign w_wr_hi     = io_bus.mtc0_we && (io_bus.mtc0_addr == AddrHi);

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= StIdle;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (io_bus.op_valid) w_state_nxt = StExec;
            StExec:  w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn)       r_op <= OpTlbp;
        else if (w_accept) r_op <= io_bus.op;
    end

`ifdef TLB_WIRED_EN
    logic [3:0] r_wired;
    logic       w_wr_wired;

    assign w_wr_wired = io_bus.mtc0_we && (io_bus.mtc0_addr == AddrWired);

    always_ff @(posedge clk) begin
        if (!resetn)         r_wired <= 4'd0;
        else if (w_wr_wired) r_wired <= io_bus.mtc0_wdata[3:0];
    end

    assign w_wired      = r_wired;
    assign w_wired_load = w_wr_wired;
`else
    assign w_wired      = 4'd0;
    assign w_wired_load = 1'b0;
`endif

    // Wraps back to the top once it reaches the Wired floor; Wired == top pins it there.
    always_ff @(posedge clk) begin
        if (!resetn)                                   r_random <= RandTop;
        else if (w_wired_load || r_random == w_wired) r_random <= RandTop;
        else                                           r_random <= r_random - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_index_p <= 1'b0;
            r_index   <= 4'd0;
        end else if (w_exec_tlbp) begin
            r_index_p <= io_bus.tlb_p_index[31];
            r_index   <= io_bus.tlb_p_index[3:0];
        end else if (w_wr_index) begin
            r_index   <= io_bus.mtc0_wdata[3:0];
        end
    end

    // Exception commit beats a tlbr result; the ASID survives the exception.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vpn2 <= '0;
            r_asid <= '0;
        end else if (io_bus.exc_tlb) begin
            r_vpn2 <= io_bus.exc_badvaddr[31:13];
        end else if (w_exec_tlbr) begin
            r_vpn2 <= io_bus.tlb_r_hi[31:13];
            r_asid <= io_bus.tlb_r_hi[7:0];
        end else if (w_wr_hi) begin
            r_vpn2 <= io_bus.mtc0_wdata[31:13];
            r_asid <= io_bus.mtc0_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lo0 <= '0;
            r_lo1 <= '0;
        end else if (w_exec_tlbr) begin
            r_lo0 <= io_bus.tlb_r_lo0[25:0];
            r_lo1 <= io_bus.tlb_r_lo1[25:0];
        end else begin
            if (w_wr_lo0) r_lo0 <= io_bus.mtc0_wdata[25:0];
            if (w_wr_lo1) r_lo1 <= io_bus.mtc0_wdata[25:0];
        end
    end

    always_comb begin
        w_tlb_we      = 1'b0;
        w_tlb_op_tlbp = 1'b0;
        w_tlb_w_index = r_index;
        if (r_state == StExec) begin
            unique case (r_op)
                OpTlbp:  w_tlb_op_tlbp = 1'b1;
                OpTlbr:  w_tlb_we      = 1'b0;
                OpTlbwi: w_tlb_we      = 1'b1;
                OpTlbwr: begin
                    w_tlb_we      = 1'b1;
                    w_tlb_w_index = r_random;
                end
                default: w_tlb_we      = 1'b0;
            endcase
        end
    end

    assign w_index_full = {r_index_p, 27'd0, r_index};
    assign w_hi_full    = {r_vpn2, 5'd0, r_asid};

    always_comb begin
        w_rdata = 32'd0;
        case (io_bus.mfc0_addr)
            AddrIndex:  w_rdata = w_index_full;
            AddrRandom: w_rdata = {28'd0, r_random};
            AddrLo0:    w_rdata = {6'd0, r_lo0};
            AddrLo1:    w_rdata = {6'd0, r_lo1};
            AddrWired:  w_rdata = {28'd0, w_wired};
            AddrHi:     w_rdata = w_hi_full;
            default:    w_rdata = 32'd0;
        endcase
    end

    assign io_bus.mfc0_rdata  = w_rdata;
    assign io_bus.op_ready    = (r_state == StIdle);
    assign io_bus.op_done     = (r_state == StDone);
    assign io_bus.tlb_we      = w_tlb_we;
    assign io_bus.tlb_op_tlbp = w_tlb_op_tlbp;
    assign io_bus.tlb_w_index = w_tlb_w_index;
    assign io_bus.tlb_w_hi    = w_hi_full;
    assign io_bus.tlb_w_lo0   = {6'd0, r_lo0};
    assign io_bus.tlb_w_lo1   = {6'd0, r_lo1};
    assign io_bus.tlb_r_index = r_index;

    assign w_unused = ^{io_bus.mtc0_wdata[12:8], io_bus.tlb_p_index[30:4], io_bus.tlb_r_hi[12:8],
                        io_bus.tlb_r_lo0[31:26], io_bus.tlb_r_lo1[31:26],
                        io_bus.exc_badvaddr[12:0]};
endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Bench for cp0_tlb_regs: hand-computed vector table, directed corner sequences, and a random
// run compared every cycle against a register-level model of the CP0 TLB registers.
module tb_cp0_tlb_regs;
`ifdef TLB_WIRED_EN
    localparam bit WiredEn = 1'b1;
`else
    localparam bit WiredEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    cp0_tlb_regs_if bus();

    cp0_tlb_regs #(.TLBNUM(16)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ov;
        logic [1:0]  op;
        logic [31:0] pidx;
        logic [31:0] rhi;
        logic [31:0] rlo0;
        logic [31:0] rlo1;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model: architectural register values plus cycles elapsed since an op was accepted.
    logic [31:0] m_index, m_hi, m_lo0, m_lo1;
    int          m_random, m_wired, m_age;
    logic [1:0]  m_op;

    logic [4:0] waddrs[7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd10, 5'd5};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd0:    return m_index;
            5'd1:    return 32'(m_random);
            5'd2:    return m_lo0;
            5'd3:    return m_lo1;
            5'd6:    return 32'(m_wired);
            5'd10:   return m_hi;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs();
        logic [3:0] widx;
        widx = (m_age == 1 && m_op == 2'b11) ? 4'(m_random) : m_index[3:0];
        chk("op_ready", 32'(bus.op_ready), 32'(m_age == 0));
        chk("op_done", 32'(bus.op_done), 32'(m_age == 2));
        chk("tlb_we", 32'(bus.tlb_we), 32'(m_age == 1 && m_op[1]));
        chk("tlb_op_tlbp", 32'(bus.tlb_op_tlbp), 32'(m_age == 1 && m_op == 2'b00));
        chk("tlb_w_index", 32'(bus.tlb_w_index), 32'(widx));
        chk("tlb_r_index", 32'(bus.tlb_r_index), 32'(m_index[3:0]));
        chk("tlb_w_hi", bus.tlb_w_hi, m_hi);
        chk("tlb_w_lo0", bus.tlb_w_lo0, m_lo0);
        chk("tlb_w_lo1", bus.tlb_w_lo1, m_lo1);
        chk("mfc0_rdata", bus.mfc0_rdata, m_read(bus.mfc0_addr));
    endtask

    task automatic model_edge();
        logic        wr;
        logic [4:0]  a;
        logic [31:0] d;
        bit          wload, exec;
        wr = bus.mtc0_we;
        a  = bus.mtc0_addr;
        d  = bus.mtc0_wdata;
        if (!resetn) begin
            m_index = 0; m_hi = 0; m_lo0 = 0; m_lo1 = 0;
            m_random = 15; m_wired = 0; m_age = 0; m_op = 2'b00;
            return;
        end
        exec  = (m_age == 1);
        wload = WiredEn && wr && a == 5'd6;
        if (wload || m_random == m_wired) m_random = 15;
        else m_random = m_random - 1;
        if (wload) m_wired = int'(d & 32'hF);
        if (exec && m_op == 2'b00) m_index = bus.tlb_p_index & 32'h8000000F;
        else if (wr && a == 5'd0) m_index = (m_index & 32'h80000000) | (d & 32'hF);
        if (bus.exc_tlb) m_hi = (bus.exc_badvaddr & 32'hFFFFE000) | (m_hi & 32'hFF);
        else if (exec && m_op == 2'b01) m_hi = bus.tlb_r_hi & 32'hFFFFE0FF;
        else if (wr && a == 5'd10) m_hi = d & 32'hFFFFE0FF;
        if (exec && m_op == 2'b01) begin
            m_lo0 = bus.tlb_r_lo0 & 32'h03FFFFFF;
            m_lo1 = bus.tlb_r_lo1 & 32'h03FFFFFF;
        end else begin
            if (wr && a == 5'd2) m_lo0 = d & 32'h03FFFFFF;
            if (wr && a == 5'd3) m_lo1 = d & 32'h03FFFFFF;
        end
        if (m_age == 0) begin
            if (bus.op_valid) begin
                m_age = 1;
                m_op  = bus.op;
            end
        end else if (m_age == 1) m_age = 2;
        else m_age = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.mfc0_addr = a;
        #1;
        chk(name, bus.mfc0_rdata, exp);
    endtask

    task automatic quiet();
        bus.mtc0_we  = 1'b0;
        bus.op_valid = 1'b0;
        bus.exc_tlb  = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.mtc0_we = 1'b1; bus.mtc0_addr = a; bus.mtc0_wdata = d;
        tick();
        bus.mtc0_we = 1'b0;
    endtask

    function automatic void add_vec(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                    input logic ov, input logic [1:0] op, input logic [31:0] pidx,
                                    input logic [31:0] rhi, input logic [31:0] rlo0,
                                    input logic [31:0] rlo1, input logic [4:0] ra,
                                    input logic [31:0] exp);
        vec_t v;
        v = '{we, wa, wd, ov, op, pidx, rhi, rlo0, rlo1, ra, exp};
        vecs.push_back(v);
    endfunction

    initial begin
        int          exp_r;
        int          floor_r;
        logic [31:0] wired_exp;

        wired_exp = WiredEn ? 32'd9 : 32'd0;
        add_vec(1, 10, 32'h00402005, 0, 0, 0, 0, 0, 0, 10, 32'h00402005);
        add_vec(1, 2,  32'h000003FF, 0, 0, 0, 0, 0, 0, 2,  32'h000003FF);
        add_vec(1, 0,  32'h00000003, 0, 0, 0, 0, 0, 0, 0,  32'h00000003);
        add_vec(1, 3,  32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 3,  32'h03FFFFFF);
        add_vec(1, 10, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 10, 32'hFFFFE0FF);
        add_vec(1, 0,  32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0,  32'h0000000F);
        add_vec(0, 0,  0, 1, 2'b00, 32'h80000000, 0, 0, 0, 0, 32'h80000000);
        add_vec(1, 0,  32'h00000002, 0, 0, 0, 0, 0, 0, 0,  32'h80000002);
        add_vec(0, 0,  0, 1, 2'b00, 32'h00000007, 0, 0, 0, 0, 32'h00000007);
        add_vec(0, 0,  0, 1, 2'b00, 32'h7FFFFFF5, 0, 0, 0, 0, 32'h00000005);
        add_vec(1, 10, 32'h00000055, 0, 0, 0, 0, 0, 0, 10, 32'h00000055);
        add_vec(0, 0,  0, 1, 2'b01, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 10,
                32'hFFFFE0FF);
        add_vec(0, 0,  0, 0, 0, 0, 0, 0, 0, 2,  32'h03FFFFFF);
        add_vec(0, 0,  0, 0, 0, 0, 0, 0, 0, 3,  32'h02345678);
        add_vec(1, 6,  32'h00000009, 0, 0, 0, 0, 0, 0, 6,  wired_exp);
        add_vec(1, 5,  32'h0000FFFF, 0, 0, 0, 0, 0, 0, 5,  32'h00000000);
        add_vec(0, 0,  0, 0, 0, 0, 0, 0, 0, 31, 32'h00000000);
        add_vec(1, 2,  32'hABCDEF01, 0, 0, 0, 0, 0, 0, 2,  32'h03CDEF01);

        bus.mtc0_we = 0; bus.mtc0_addr = 0; bus.mtc0_wdata = 0; bus.mfc0_addr = 0;
        bus.op_valid = 0; bus.op = 0; bus.exc_tlb = 0; bus.exc_badvaddr = 0;
        bus.tlb_p_index = 0; bus.tlb_r_hi = 0; bus.tlb_r_lo0 = 0; bus.tlb_r_lo1 = 0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        tick();
        resetn = 1'b1;
        chk_en = 1'b1;

        // Reset state
        rd("rst_index", 5'd0, 32'h0);
        rd("rst_random", 5'd1, 32'd15);
        rd("rst_entryhi", 5'd10, 32'h0);
        chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
        tick();

        // Random countdown against the Wired floor, starting from a fresh reset
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        bus.mfc0_addr = 5'd1;
        mtc0(5'd6, 32'd4);
        floor_r = WiredEn ? 4 : 0;
        exp_r   = WiredEn ? 15 : 14;
        for (int i = 0; i < 24; i++) begin
            #1;
            chk("random_seq", bus.mfc0_rdata, 32'(exp_r));
            tick();
            exp_r = (exp_r == floor_r) ? 15 : exp_r - 1;
        end

        foreach (vecs[i]) begin
            bus.mtc0_we = vecs[i].we; bus.mtc0_addr = vecs[i].waddr;
            bus.mtc0_wdata = vecs[i].wdata; bus.op_valid = vecs[i].ov; bus.op = vecs[i].op;
            bus.tlb_p_index = vecs[i].pidx; bus.tlb_r_hi = vecs[i].rhi;
            bus.tlb_r_lo0 = vecs[i].rlo0; bus.tlb_r_lo1 = vecs[i].rlo1;
            tick();
            quiet();
            bus.mfc0_addr = vecs[i].raddr;
            repeat (3) tick();
            #1;
            chk($sformatf("vec%0d", i), bus.mfc0_rdata, vecs[i].exp);
        end

        // tlbwi drive and completion timing
        mtc0(5'd10, 32'h00402005);
        mtc0(5'd2, 32'h000003FF);
        mtc0(5'd0, 32'd3);
        bus.op_valid = 1'b1; bus.op = 2'b10;
        tick();
        bus.op_valid = 1'b0;
        #1;
        chk("wi_we", 32'(bus.tlb_we), 32'd1);
        chk("wi_index", 32'(bus.tlb_w_index), 32'd3);
        chk("wi_lo0", bus.tlb_w_lo0, 32'h3FF);
        chk("wi_hi", bus.tlb_w_hi, 32'h00402005);
        chk("wi_done_early", 32'(bus.op_done), 32'd0);
        tick();
        chk("wi_done", 32'(bus.op_done), 32'd1);
        chk("wi_we_off", 32'(bus.tlb_we), 32'd0);
        tick();
        chk("wi_ready", 32'(bus.op_ready), 32'd1);
        tick();

        // mtc0 Index in the accept cycle reaches the EXEC drive
        bus.op_valid = 1'b1; bus.op = 2'b10;
        bus.mtc0_we = 1'b1; bus.mtc0_addr = 5'd0; bus.mtc0_wdata = 32'd9;
        tick();
        quiet();
        #1;
        chk("acc_mtc0_index", 32'(bus.tlb_w_index), 32'd9);
        repeat (2) tick();

        // exc_tlb beats a same-cycle mtc0 EntryHi and keeps ASID
        mtc0(5'd10, 32'h000000AB);
        bus.exc_tlb = 1'b1; bus.exc_badvaddr = 32'h12345678;
        bus.mtc0_we = 1'b1; bus.mtc0_addr = 5'd10; bus.mtc0_wdata = 32'h0;
        tick();
        quiet();
        rd("exc_vs_mtc0", 5'd10, 32'h123440AB);
        tick();

        // exc_tlb beats the tlbr result on EntryHi; EntryLo still loads
        bus.op_valid = 1'b1; bus.op = 2'b01;
        bus.tlb_r_hi = 32'hFFFFFFFF; bus.tlb_r_lo0 = 32'hFFFFFFFF; bus.tlb_r_lo1 = 32'h0;
        tick();
        bus.op_valid = 1'b0;
        bus.exc_tlb = 1'b1; bus.exc_badvaddr = 32'h0000E000;
        tick();
        bus.exc_tlb = 1'b0;
        rd("exc_vs_tlbr_hi", 5'd10, 32'h0000E0AB);
        rd("exc_vs_tlbr_lo0", 5'd2, 32'h03FFFFFF);
        repeat (2) tick();

        // Reset in EXEC: write strobe already out, no op_done afterwards
        bus.op_valid = 1'b1; bus.op = 2'b10;
        tick();
        bus.op_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_exec_we", 32'(bus.tlb_we), 32'd1);
        tick();
        resetn = 1'b1;
        #1;
        chk("rst_exec_done", 32'(bus.op_done), 32'd0);
        chk("rst_exec_ready", 32'(bus.op_ready), 32'd1);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            bus.mtc0_we      = ($urandom_range(0, 3) == 0);
            bus.mtc0_addr    = waddrs[$urandom_range(0, 6)];
            bus.mtc0_wdata   = $urandom;
            bus.mfc0_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                           : waddrs[$urandom_range(0, 6)];
            bus.op_valid     = ($urandom_range(0, 2) == 0);
            bus.op           = 2'($urandom_range(0, 3));
            bus.exc_tlb      = ($urandom_range(0, 15) == 0);
            bus.exc_badvaddr = $urandom;
            bus.tlb_p_index  = $urandom;
            bus.tlb_r_hi     = $urandom;
            bus.tlb_r_lo0    = $urandom;
            bus.tlb_r_lo1    = $urandom;
            resetn           = ($urandom_range(0, 99) != 0);
            tick();
        end
        resetn = 1'b1;
        quiet();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
